// File: rtl/fetch_pkg.sv
// Shared definitions for the PC / fetch-control stage.
//   fetch_state_t  : FSM encoding (BOOT, RUN, HALT, ERROR)
//   INSTR_BYTES    : bytes per instruction word
//   PC_ALIGN_BITS  : low PC bits that must be zero for a word fetch
//   addr_legal()   : word-aligned and within 0 .. INSTR_BYTES*(words-1)
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES   = 32'd4;
  localparam int unsigned PC_ALIGN_BITS = 2;

  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] words);
    logic [31:0] last;
    last = (words - 32'd1) * INSTR_BYTES;
    return (addr[PC_ALIGN_BITS-1:0] == '0) && (addr <= last);
  endfunction

endpackage

// File: rtl/pc_target_check.sv
// Combinational legality check for a candidate fetch address.
//   addr_i  : candidate PC (redirect target or sequential pc+4)
//   legal_o : 1 when addr_i is word-aligned and inside instruction memory
module pc_target_check
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 1001
) (
  input  logic [31:0] addr_i,
  output logic        legal_o
);

  assign legal_o = addr_legal(addr_i, 32'(IMEM_WORDS));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control in front of the word-indexed imem.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hold current PC
//   redirect_valid/_target : taken branch/jump and its destination
//   halt_req, resume  : enter / leave HALT
//   pc, pc_plus4      : current fetch PC and its link value
//   fetch_valid       : pc is a legal fetch this cycle (state RUN)
//   halted, err       : in HALT / in ERROR (sticky until rst)
//   err_addr          : first offending address
//   fetch_count       : saturating count of accepted fetches
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  err_addr_q, err_addr_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         cnt_inc;
  logic         tgt_ok, seq_ok;
  logic [31:0]  seq_pc;

  assign seq_pc = pc_q + INSTR_BYTES;

  pc_target_check #(.IMEM_WORDS(IMEM_WORDS)) u_tgt_chk (
    .addr_i  (redirect_target),
    .legal_o (tgt_ok)
  );

  pc_target_check #(.IMEM_WORDS(IMEM_WORDS)) u_seq_chk (
    .addr_i  (seq_pc),
    .legal_o (seq_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      err_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_addr_d = err_addr_q;
    cnt_inc    = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          if (!tgt_ok) begin
            state_d    = ERROR;
            err_addr_d = redirect_target;
          end else begin
            // redirect outranks stall and halt so it is never dropped
            pc_d    = redirect_target;
            cnt_inc = !stall;
          end
        end else if (halt_req) begin
          state_d = HALT;
          cnt_inc = !stall;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (!seq_ok) begin
          // running off the end of imem is a fault, never a wrap
          state_d    = ERROR;
          err_addr_d = seq_pc;
        end else begin
          pc_d    = seq_pc;
          cnt_inc = 1'b1;
        end
      end
      HALT: begin
        if (resume && !halt_req) state_d = RUN;
      end
      ERROR: state_d = ERROR;
      default: state_d = BOOT;
    endcase
  end

  assign cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;

  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign err         = (state_q == ERROR);
  assign err_addr    = err_addr_q;
  assign fetch_count = cnt_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage directly upstream of the word-indexed instruction memory. It owns the PC register, selects the next PC from sequential increment, branch/jump redirect, stall and halt, and drives the PC that the instruction memory divides by 4. It guarantees that every PC presented while fetch_valid=1 is word-aligned and inside the memory range. It flags misaligned or out-of-range targets as a sticky error.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded by reset; must be word-aligned.
IMEM_WORDS, 1001, number of instruction words; the valid PC range is 0 .. 4*(IMEM_WORDS-1).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
stall  in  1  hold the current PC (hazard or memory wait)
redirect_valid  in  1  taken branch or jump this cycle
redirect_target  in  32  new PC when redirect_valid=1
halt_req  in  1  request to stop fetching
resume  in  1  leave HALT and continue from the held PC
pc  out  32  current PC, goes to the instruction memory address
pc_plus4  out  32  pc+4, for JAL/JALR link writeback
fetch_valid  out  1  pc is a legal fetch address this cycle
halted  out  1  FSM is in HALT
err  out  1  sticky fault: misaligned or out-of-range target
err_addr  out  32  offending address, latched on the first fault
fetch_count  out  32  number of fetches accepted, saturating

Behaviour:
- Reset (rst=1 at a clk edge): state=BOOT, pc=RESET_VEC, fetch_valid=0, halted=0, err=0, err_addr=0, fetch_count=0. rst overrides every other input, including in ERROR state and mid-stall.
- pc_plus4 = pc+4 (combinational, modulo 2^32). fetch_valid = (state==RUN).
- States:
  - BOOT: lasts one cycle, then RUN. pc stays RESET_VEC, so the first valid fetch is RESET_VEC.
  - RUN: evaluate the next PC in this priority order:
    1. redirect_valid with target[1:0]!=0 or target>4*(IMEM_WORDS-1): go to ERROR, err_addr=target, pc unchanged.
    2. redirect_valid (legal): pc=target. Redirect wins over stall and halt_req; the redirect is never lost.
    3. halt_req: go to HALT, pc unchanged.
    4. stall: pc unchanged.
    5. Otherwise pc=pc+4. If pc+4>4*(IMEM_WORDS-1), go to ERROR with err_addr=pc+4 and pc unchanged. There is no wrap-around.
  - fetch_count increments on every RUN cycle with stall=0 and no transition to ERROR. It saturates at 32'hFFFF_FFFF.
  - HALT: halted=1, pc held, redirect and stall ignored. resume=1 returns to RUN the next cycle with the same pc. halt_req and resume both high: stay in HALT.
  - ERROR: err=1, fetch_valid=0, pc and err_addr frozen. Only rst exits. halted=0.
- Single-cycle latency: inputs sampled at edge N take effect on pc at edge N, so the new pc is visible after edge N.
- err_addr is written only on the transition into ERROR.

Decomposition:
- Shared package fetch_pkg:
  - enum fetch_state_t {BOOT, RUN, HALT, ERROR}
  - constants INSTR_BYTES=4 and PC_ALIGN_BITS=2
  - function addr_legal(addr, words)
- Natural sub-module: pc_target_check, a combinational alignment/range check instantiated twice (redirect target and sequential pc+4).
- The saturating counter stays inline.

Test Plan:
- Reset then 4 idle cycles: pc sequence 0 (BOOT, fetch_valid=0), 0, 4, 8, 12. fetch_count=3 after the 4th cycle.
- At pc=0x10, stall=1 for 2 cycles, then redirect_valid=1 with target=0x40 while stall=1: pc holds 0x10 twice, then 0x40. fetch_count unchanged across the stall.
- redirect_target=0x42: next cycle err=1, err_addr=0x42, fetch_valid=0, pc unchanged. Further redirects are ignored. rst clears err and pc=0.
- IMEM_WORDS=4, run from 0: pc 0, 4, 8, 12, then ERROR with err_addr=16 and pc=12.
- halt_req at pc=0x8: halted=1 and pc=0x8 held for 3 cycles despite redirect_valid. resume: halted=0, then pc advances 0x8 → 0xC.
- rst asserted mid-HALT and mid-stall: next cycle state=BOOT, pc=RESET_VEC, all flags cleared.
